stream_sampler: RTL and testbench
=================================

Name: stream_sampler

Overview:
- Parametrised successor to the fixed 32-bit, always-on sampler path between fabric and the HPS.
- Captures CHANNELS × WIDTH-bit samples from fabric logic with programmable decimation, trigger mode and capture length.
- Buffers samples in a DEPTH-entry FIFO and presents them on a valid/ready stream toward the HPS-side sample port.
- Exposes status (state, count, overflow) for HPS readback and LED display.

Parameters:
- WIDTH, 32, bits per channel sample
- CHANNELS, 1, channels captured together per sample word; data bus width is CHANNELS*WIDTH
- DEPTH, 512, FIFO entries; power of two, ≥ 4
- CNT_W, 16, width of capture_len, count and decim

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; starts a capture sequence
- stop  in  1  single-cycle pulse; ends capture early
- mode  in  2  trigger mode: 0 = immediate, 1 = rising edge, 2 = level high, 3 = reserved (treated as 0)
- trig_mask  in  WIDTH  selects the channel-0 bits that participate in triggering
- decim  in  CNT_W  take one sample every decim+1 cycles
- capture_len  in  CNT_W  samples per capture; 0 = continuous
- sample_in  in  CHANNELS*WIDTH  live fabric data
- out_data  out  CHANNELS*WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head word
- state  out  2  IDLE = 0, ARMED = 1, CAPTURE = 2, DONE = 3
- count  out  CNT_W  sample strobes issued in the current capture
- overflow  out  1  sticky; set when a sample was dropped on a full FIFO
- active  out  1  high in ARMED or CAPTURE

Behaviour:
- Reset (asynchronous): state = IDLE; count = 0; overflow = 0; FIFO emptied; out_valid = 0; out_data = 0; decimation and trigger-history registers = 0.
- IDLE or DONE, arm = 1 → ARMED next cycle. On entry: count cleared, overflow cleared, decimation counter loaded with 0. FIFO contents are not flushed.
- arm while in ARMED or CAPTURE is ignored.
- ARMED trigger, with t = sample_in[WIDTH-1:0] & trig_mask and t_prev = t registered from the previous cycle:
  - mode 0 or 3: go to CAPTURE the cycle after ARMED is entered.
  - mode 1: trigger when (t & ~t_prev) != 0.
  - mode 2: trigger when t != 0.
  - On trigger, state = CAPTURE next cycle, and sample_in on that trigger cycle is the first sample.
- CAPTURE sample strobe:
  - Asserted when the decimation counter == 0; the counter then reloads with decim. Otherwise it decrements.
  - decim = 0 → strobe every cycle.
- Each strobe:
  - Increments count.
  - Pushes sample_in if the FIFO is not full; otherwise sets overflow and drops the sample.
- Capture end:
  - capture_len != 0 and the strobe makes count == capture_len → DONE next cycle.
  - stop = 1 in ARMED or CAPTURE → DONE next cycle. stop has priority over a same-cycle trigger or strobe; that strobe is not pushed.
- count saturates at all-ones when capture_len = 0.
- FIFO is first-word-fall-through:
  - A word pushed at cycle N gives out_valid = 1 with out_data = that word at cycle N+1.
  - Pop occurs when out_valid & out_ready.
  - A simultaneous push and pop is allowed at any occupancy, including full, because the pop frees the slot first.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the rest are equal.
- Draining continues in DONE and IDLE. state does not depend on FIFO occupancy.
- mode, trig_mask, decim and capture_len are sampled continuously. Changing them mid-capture takes effect immediately; software must not do this.

Decomposition:
- Package stream_sampler_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE);
  - the mode constants MODE_IMM, MODE_RISE, MODE_LEVEL;
  - the function clog2.
- Sub-module sample_fifo: parametrised synchronous FWFT FIFO (DATA_W, DEPTH) with push/full/pop/empty. Control FSM, decimation and trigger logic live in stream_sampler.

Test Plan:
- Reset mid-CAPTURE with 5 words queued → state = 0, out_valid = 0, count = 0, overflow = 0 on the cycle reset asserts.
- mode 0, decim = 0, capture_len = 4, sample_in = cycle counter starting at 10 on the CAPTURE cycle, out_ready = 1 → out_data 10, 11, 12, 13 on consecutive cycles, then DONE, count = 4.
- mode 1, trig_mask = 0x1, bit 0 held low for 8 cycles then rising, decim = 2, capture_len = 3 → samples taken on trigger cycle +0, +3, +6; no sample before the rising edge.
- DEPTH = 4, out_ready = 0, capture_len = 6, decim = 0 → 4 words stored, overflow = 1, count = 6, DONE; subsequent drain yields the first 4 samples in order.
- FIFO full with out_ready = 1 during capture → simultaneous push and pop each cycle, no overflow, occupancy stays 4.
- capture_len = 0 with stop pulse after 7 strobes → DONE next cycle, count = 7; arm in DONE → ARMED with count = 0.

Source files
------------

// File: rtl/stream_sampler_pkg.sv
// Shared types and constants for the stream_sampler capture path.
package stream_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_IMM   = 2'd0;
  localparam logic [1:0] MODE_RISE  = 2'd1;
  localparam logic [1:0] MODE_LEVEL = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_sampler_fifo.sv
// First-word-fall-through FIFO; a pop frees its slot for a same-cycle push.
module sample_fifo
  import stream_sampler_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stream_sampler.sv
// Triggered, decimating sample capture from fabric into a FWFT FIFO for the HPS.
module stream_sampler
  import stream_sampler_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          trig_mask,
  input  logic [CNT_W-1:0]          decim,
  input  logic [CNT_W-1:0]          capture_len,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          count,
  output logic                      overflow,
  output logic                      active
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] trig_bits;
  logic [WIDTH-1:0] trig_prev;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] count_inc;
  logic             trig_mode;
  logic             trig_hit;
  logic             arm_accept;
  logic             trig_strobe;
  logic             cap_strobe;
  logic             strobe;
  logic             len_hit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign trig_bits = sample_in[WIDTH-1:0] & trig_mask;

  // Immediate and reserved modes report a hit unconditionally but never strobe in ARMED.
  always_comb begin
    trig_mode = 1'b0;
    trig_hit  = 1'b1;
    case (mode)
      MODE_RISE: begin
        trig_mode = 1'b1;
        trig_hit  = |(trig_bits & ~trig_prev);
      end
      MODE_LEVEL: begin
        trig_mode = 1'b1;
        trig_hit  = |trig_bits;
      end
      default: ;
    endcase
  end

  assign strobe    = trig_strobe || cap_strobe;
  assign count_inc = (count == '1) ? count : count + CNT_W'(1);
  assign len_hit   = strobe && (capture_len != '0) && (count_inc == capture_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (arm) state_d = ARMED;
      ARMED: begin
        if (stop || len_hit) state_d = DONE;
        else if (trig_hit)   state_d = CAPTURE;
      end
      CAPTURE: if (stop || len_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // stop wins over a same-cycle trigger or decimation strobe.
  always_comb begin
    active      = 1'b0;
    arm_accept  = 1'b0;
    trig_strobe = 1'b0;
    cap_strobe  = 1'b0;
    case (state_q)
      IDLE, DONE: arm_accept = arm;
      ARMED: begin
        active      = 1'b1;
        trig_strobe = !stop && trig_mode && trig_hit;
      end
      CAPTURE: begin
        active     = 1'b1;
        cap_strobe = !stop && (dcnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      dcnt      <= '0;
      trig_prev <= '0;
    end else begin
      trig_prev <= trig_bits;
      if (arm_accept) begin
        count    <= '0;
        overflow <= 1'b0;
        dcnt     <= '0;
      end else if (strobe) begin
        count <= count_inc;
        dcnt  <= decim;
        if (fifo_full && !fifo_pop) overflow <= 1'b1;
      end else if (state_q == CAPTURE && dcnt != '0) begin
        dcnt <= dcnt - CNT_W'(1);
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign state     = state_q;

  sample_fifo #(
    .DATA_W(CHANNELS*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (strobe),
    .push_data(sample_in),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_data (out_data),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_stream_sampler.sv
// Directed and randomized checks of stream_sampler against a cycle-level reference model.
module tb_stream_sampler;

  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm, stop, out_ready;
  logic [1:0]    mode;
  logic [W-1:0]  trig_mask;
  logic [CW-1:0] decim, capture_len;
  logic [CH*W-1:0] sample_in;

  logic [CH*W-1:0] out_data, out_data8;
  logic            out_valid, out_valid8;
  logic [1:0]      state, state8;
  logic [CW-1:0]   count, count8;
  logic            overflow, overflow8, active, active8;

  stream_sampler #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode), .trig_mask(trig_mask),
    .decim(decim), .capture_len(capture_len), .sample_in(sample_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .state(state), .count(count),
    .overflow(overflow), .active(active));

  stream_sampler #(.WIDTH(W), .CHANNELS(CH), .DEPTH(8), .CNT_W(CW)) dut8 (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode), .trig_mask(trig_mask),
    .decim(decim), .capture_len(capture_len), .sample_in(sample_in), .out_data(out_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .state(state8), .count(count8),
    .overflow(overflow8), .active(active8));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state as 0..3, FIFO as a queue.
  int              m_state, m_count, m_dc;
  bit              m_ovf;
  logic [W-1:0]    m_tprev;
  logic [CH*W-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_dc = 0; m_ovf = 0; m_tprev = '0;
    q.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] t;
    bit pop, take;
    int nst;
    t    = sample_in[W-1:0] & trig_mask;
    pop  = (q.size() > 0) && out_ready;
    take = 0;
    nst  = m_state;
    case (m_state)
      0, 3: if (arm) begin nst = 1; m_count = 0; m_ovf = 0; m_dc = 0; end
      1: begin
        if (stop) nst = 3;
        else if (mode == 2'd1 || mode == 2'd2) begin
          if ((mode == 2'd1 && (t & ~m_tprev) != 0) || (mode == 2'd2 && t != 0)) begin
            take = 1; nst = 2;
          end
        end else nst = 2;
      end
      default: begin
        if (stop) nst = 3;
        else if (m_dc == 0) take = 1;
        else m_dc--;
      end
    endcase
    if (pop) void'(q.pop_front());
    if (take) begin
      m_dc = int'(decim);
      if (m_count < 255) m_count++;
      if (q.size() < DEPTH) q.push_back(sample_in);
      else m_ovf = 1;
      if (capture_len != 0 && m_count == int'(capture_len)) nst = 3;
    end
    m_state = nst;
    m_tprev = t;
  endtask

  task automatic compare_all();
    chk("m_state", 32'(state), m_state);
    chk("m_count", 32'(count), m_count);
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_active", 32'(active), 32'(m_state == 1 || m_state == 2));
    if (q.size() > 0) chk("m_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [CH*W-1:0] rep(input int v);
    logic [W-1:0] b;
    b = W'(v);
    return {CH{b}};
  endfunction

  initial begin
    int n;
    reset = 1'b1; arm = 0; stop = 0; out_ready = 0; mode = 0;
    trig_mask = '1; decim = '0; capture_len = '0; sample_in = '0;
    model_reset();
    @(posedge clk); #1;
    chk("init_state", 32'(state), 0);
    chk("init_valid", 32'(out_valid), 0);
    chk("init_data", 32'(out_data), 0);
    reset = 1'b0;

    // Reset while capturing with five words queued in the deeper instance.
    arm = 1; cycle(); arm = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin sample_in = rep(40 + i); cycle(); end
    chk("pre_rst_state8", 32'(state8), 2);
    chk("pre_rst_valid8", 32'(out_valid8), 1);
    chk("pre_rst_ovf", 32'(overflow), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_state8", 32'(state8), 0);
    chk("rst_valid8", 32'(out_valid8), 0);
    chk("rst_count8", 32'(count8), 0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;

    // Immediate mode, no decimation, four samples streamed out.
    out_ready = 1; mode = 0; decim = 0; capture_len = 4; sample_in = '0;
    arm = 1; cycle(); arm = 0;
    chk("t1_armed", 32'(state), 1);
    cycle();
    chk("t1_capture", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      sample_in = rep(10 + i); cycle();
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'(rep(10 + i)));
    end
    chk("t1_done", 32'(state), 3);
    chk("t1_count", 32'(count), 4);
    sample_in = '0; cycle();
    chk("t1_drained", 32'(out_valid), 0);

    // Rising-edge trigger on bit 0, decimation 2, three samples.
    trig_mask = 8'h01; mode = 1; decim = 2; capture_len = 3;
    arm = 1; cycle(); arm = 0;
    for (int i = 0; i < 8; i++) begin
      sample_in = rep(2 * i + 2); cycle();
      chk("t2_wait_state", 32'(state), 1);
      chk("t2_wait_valid", 32'(out_valid), 0);
    end
    for (int i = 0; i < 7; i++) begin
      sample_in = rep(2 * i + 61); cycle();
      if (i % 3 == 0) begin
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data", 32'(out_data), 32'(rep(2 * i + 61)));
      end else chk("t2_gap", 32'(out_valid), 0);
    end
    chk("t2_done", 32'(state), 3);
    chk("t2_count", 32'(count), 3);
    cycle();

    // Overflow with consumer stalled, then drain.
    out_ready = 0; mode = 0; decim = 0; capture_len = 6; trig_mask = '1;
    arm = 1; cycle(); arm = 0;
    cycle();
    for (int i = 0; i < 6; i++) begin sample_in = rep(30 + i); cycle(); end
    chk("t3_done", 32'(state), 3);
    chk("t3_count", 32'(count), 6);
    chk("t3_ovf", 32'(overflow), 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", 32'(out_valid), 1);
      chk("t3_drain_data", 32'(out_data), 32'(rep(30 + i)));
      cycle();
    end
    chk("t3_empty", 32'(out_valid), 0);

    // Full FIFO with simultaneous push and pop.
    out_ready = 0; capture_len = 0;
    arm = 1; cycle(); arm = 0;
    cycle();
    for (int i = 0; i < 4; i++) begin sample_in = rep(50 + i); cycle(); end
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      sample_in = rep(54 + i);
      chk("t4_head", 32'(out_data), 32'(rep(50 + i)));
      cycle();
      chk("t4_no_ovf", 32'(overflow), 0);
    end
    out_ready = 0; stop = 1; cycle(); stop = 0;
    chk("t4_done", 32'(state), 3);
    chk("t4_count", 32'(count), 9);
    out_ready = 1; n = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) n++;
      cycle();
    end
    chk("t4_occupancy", n, 4);

    // Continuous capture ended by stop, then re-arm from DONE.
    arm = 1; cycle(); arm = 0;
    cycle();
    for (int i = 0; i < 7; i++) begin sample_in = rep(70 + i); cycle(); end
    stop = 1; sample_in = rep(99); cycle(); stop = 0;
    chk("t5_done", 32'(state), 3);
    chk("t5_count", 32'(count), 7);
    arm = 1; cycle(); arm = 0;
    chk("t5_rearm_state", 32'(state), 1);
    chk("t5_rearm_count", 32'(count), 0);
    stop = 1; cycle(); stop = 0;

    // Count saturation in continuous mode.
    arm = 1; cycle(); arm = 0;
    for (int k = 0; k < 262; k++) begin sample_in = CH*W'($urandom); cycle(); end
    chk("sat_count", 32'(count), 255);
    stop = 1; cycle(); stop = 0;

    // Randomized configurations and traffic.
    for (int r = 0; r < 10; r++) begin
      mode = 2'($urandom_range(0, 3));
      trig_mask = W'($urandom);
      decim = CW'($urandom_range(0, 3));
      capture_len = CW'($urandom_range(0, 8));
      arm = 1; cycle(); arm = 0;
      for (int k = 0; k < 40; k++) begin
        sample_in = CH*W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        stop = ($urandom_range(0, 29) == 0);
        arm = ($urandom_range(0, 19) == 0);
        cycle();
      end
      arm = 0; stop = 0;
    end
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
